// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller.
// Default widths, reset PC, FSM encodings and the PC step.
// Also holds a small sizing helper used by the top and its FIFO.
package fetch_controller_pkg;

  localparam int          FC_ADDR_W    = 32;
  localparam int          FC_INST_W    = 32;
  localparam logic [31:0] FC_RESET_PC  = 32'h0000_0000;
  localparam int          FC_BUF_DEPTH = 2;
  localparam int          FC_PC_INC    = 4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fc_state_e;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int fc_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Bundles the ROM read port, the decode handshake and the core controls.
// master: fetch controller side. slave: ROM / decode / core side.
// Pure wiring, no state.
interface fetch_controller_if
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W = FC_ADDR_W,
  parameter int INST_W = FC_INST_W
) ();

  // ROM read port
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;

  // Decode handshake
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  // Core controls
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              halted;

  modport master (
    output rom_en, rom_addr, inst_valid, inst_data, inst_pc, halted,
    input  rom_data, inst_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  rom_en, rom_addr, inst_valid, inst_data, inst_pc, halted,
    output rom_data, inst_ready, redirect_valid, redirect_pc, halt_req
  );

endinterface

// File: rtl/fetch_controller_fifo.sv
// Prefetch buffer: synchronous FIFO of {instruction, pc} entries with flush.
// Latency: a push becomes visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module fetch_controller_fifo
  import fetch_controller_pkg::*;
#(
  parameter  int DEPTH = FC_BUF_DEPTH,
  parameter  int WIDTH = FC_INST_W + FC_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fc_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // A flush wins over everything; a full FIFO may still accept a push alongside a pop.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: owns the PC, issues ROM reads, buffers words for decode.
// Latency: first inst_valid two cycles after the first rom_en (issue, push, head).
// Backpressure: decode stall fills the buffer, then issue stops; nothing is dropped.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int                ADDR_W    = FC_ADDR_W,
  parameter int                INST_W    = FC_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FC_RESET_PC),
  parameter int                BUF_DEPTH = FC_BUF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_controller_if.master bus_if
);

  localparam int                ENT_W   = INST_W + ADDR_W;
  localparam int                CNT_W   = fc_cnt_w(BUF_DEPTH);
  localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(3);

  fc_state_e         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] tag_pc_q;
  logic              in_flight_q;
  logic              halted_q;
  logic [INST_W-1:0] hold_inst_q;
  logic [ADDR_W-1:0] hold_pc_q;

  logic              redir;
  logic              inst_vld;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    demand;

  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;

  assign head_inst = fifo_head[ENT_W-1:ADDR_W];
  assign head_pc   = fifo_head[ADDR_W-1:0];

  // Issue / handshake decisions for the current cycle; a redirect overrides everything.
  always_comb begin
    redir    = bus_if.redirect_valid && (state_q != S_BOOT);
    inst_vld = !fifo_empty && !redir;
    pop      = inst_vld && bus_if.inst_ready;
    // Entries staying in the buffer plus the word still coming back from the ROM.
    demand   = {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop}
             + {{CNT_W{1'b0}}, in_flight_q};
    issue    = (state_q == S_RUN) && !bus_if.halt_req && !redir
             && (demand < DEPTH_L) && (!fifo_full || pop);
    // A redirect kills the returning word by simply not pushing it.
    push     = in_flight_q && !redir;
    pc_d     = pc_q;
    if (redir) begin
      pc_d = bus_if.redirect_pc & ALIGN_M;
    end else if (issue) begin
      pc_d = pc_q + ADDR_W'(FC_PC_INC);
    end
  end

  // Control FSM together with PC, in-flight tag and the registered halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      tag_pc_q    <= '0;
      in_flight_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= issue;
      if (issue) tag_pc_q <= pc_q;
      case (state_q)
        S_BOOT: begin
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
        S_RUN: begin
          // Halt only once the last issued read has landed in the buffer.
          if (!redir && bus_if.halt_req && !in_flight_q) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_HALT: begin
          // A redirect while halt is still requested only moves the PC.
          if (!bus_if.halt_req) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Remember the last head so an empty buffer keeps presenting the previous word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
    end else if (!fifo_empty) begin
      hold_inst_q <= head_inst;
      hold_pc_q   <= head_pc;
    end
  end

  fetch_controller_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i ({bus_if.rom_data, tag_pc_q}),
    .pop_i      (pop),
    .flush_i    (redir),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign bus_if.rom_en     = issue;
  assign bus_if.rom_addr   = pc_q;
  assign bus_if.inst_valid = inst_vld;
  assign bus_if.inst_data  = fifo_empty ? hold_inst_q : head_inst;
  assign bus_if.inst_pc    = fifo_empty ? hold_pc_q : head_pc;
  assign bus_if.halted     = halted_q;

endmodule
